// File: rtl/icache_dm_ro.sv
// Read-only direct-mapped instruction cache: single-cycle hits, stalling
// 128-bit line refill from slow memory, saturating refill counter.
module icache_dm_ro #(
    parameter int LINE_CNT = 8,
    parameter int IDX_W    = 3,
    parameter int TAG_W    = 25
) (
    input  logic           clk,
    input  logic           proc_reset,
    input  logic           proc_read,
    input  logic [29:0]    proc_addr,
    output logic [31:0]    proc_rdata,
    output logic           proc_stall,
    output logic           mem_read,
    output logic           mem_write,
    output logic [27:0]    mem_addr,
    output logic [127:0]   mem_wdata,
    input  logic [127:0]   mem_rdata,
    input  logic           mem_ready,
    output logic [15:0]    miss_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_REFILLED = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [LINE_CNT-1:0] valid_r;
    logic [TAG_W-1:0]    tag_r  [LINE_CNT];
    logic [127:0]        data_r [LINE_CNT];
    logic [27:0]         miss_addr_r;
    logic [15:0]         miss_cnt_r;

    logic [TAG_W-1:0]    req_tag_s;
    logic [IDX_W-1:0]    req_idx_s;
    logic [1:0]          req_word_s;
    logic [IDX_W-1:0]    fill_idx_s;
    logic [TAG_W-1:0]    fill_tag_s;
    logic [127:0]        req_line_s;
    logic [31:0]         req_word_data_s;
    logic                hit_s;
    logic                miss_start_s;
    logic                refill_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign req_tag_s    = proc_addr[29 -: TAG_W];
    assign req_idx_s    = proc_addr[2 +: IDX_W];
    assign req_word_s   = proc_addr[1:0];
    assign fill_idx_s   = miss_addr_r[IDX_W-1:0];
    assign fill_tag_s   = miss_addr_r[27 -: TAG_W];
    assign req_line_s   = data_r[req_idx_s];
    assign hit_s        = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
    assign miss_start_s = (state_r == ST_IDLE) && proc_read && !hit_s;
    assign refill_s     = (state_r == ST_FETCH) && mem_ready;

    assign mem_write = 1'b0;
    assign mem_wdata = 128'd0;
    assign mem_addr  = miss_addr_r;
    assign miss_cnt  = miss_cnt_r;

    // Select the requested 32-bit word out of the indexed line
    always_comb begin
        req_word_data_s = 32'd0;
        case (req_word_s)
            2'd0:    req_word_data_s = req_line_s[31:0];
            2'd1:    req_word_data_s = req_line_s[63:32];
            2'd2:    req_word_data_s = req_line_s[95:64];
            2'd3:    req_word_data_s = req_line_s[127:96];
            default: req_word_data_s = 32'd0;
        endcase
    end

    // State, valid bits, latched miss address and refill counter
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_r     <= ST_IDLE;
            valid_r     <= '0;
            miss_addr_r <= 28'd0;
            miss_cnt_r  <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            if (miss_start_s) begin
                miss_addr_r <= proc_addr[29:2];
                miss_cnt_r  <= sat_inc(miss_cnt_r);
            end
            if (refill_s) begin
                valid_r[fill_idx_s] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset; valid bits alone qualify them
    always_ff @(posedge clk) begin
        if (refill_s) begin
            tag_r[fill_idx_s]  <= fill_tag_s;
            data_r[fill_idx_s] <= mem_rdata;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (miss_start_s) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    state_nxt_s = ST_REFILLED;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_REFILLED: state_nxt_s = ST_IDLE;
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // Outputs; all forced quiet while reset is held
    always_comb begin
        mem_read   = 1'b0;
        proc_stall = 1'b0;
        proc_rdata = 32'd0;
        if (proc_reset) begin
            mem_read   = 1'b0;
            proc_stall = 1'b0;
            proc_rdata = 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    proc_stall = proc_read && !hit_s;
                    if (proc_read && hit_s) begin
                        proc_rdata = req_word_data_s;
                    end else begin
                        proc_rdata = 32'd0;
                    end
                end
                ST_FETCH: begin
                    mem_read   = 1'b1;
                    proc_stall = 1'b1;
                end
                ST_REFILLED: begin
                    proc_stall = 1'b1;
                end
                default: begin
                    mem_read   = 1'b0;
                    proc_stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm_ro.sv
// Directed bench for icache_dm_ro; slow memory returns word address + 1 in
// every word so expected data follows directly from the requested address.
module tb_icache_dm_ro;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         proc_read;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic [15:0]  miss_cnt;

    int checks   = 0;
    int failures = 0;

    icache_dm_ro dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_addr  (proc_addr),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] line_data(input logic [27:0] la);
        logic [127:0] d;
        logic [29:0]  w;
        d = 128'd0;
        for (int k = 0; k < 4; k++) begin
            w = {la, 2'(k)};
            d[32*k +: 32] = {2'b00, w} + 32'd1;
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one read; serve a miss with mem_ready in the r-th FETCH cycle
    task automatic access(input string tag, input logic [29:0] a, input int r, input bit exp_miss);
        int          stalls;
        int          fetch_n;
        logic [27:0] seen_maddr;
        stalls     = 0;
        fetch_n    = 0;
        seen_maddr = 28'hFFFFFFF;
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = a;
        #1;
        while (proc_stall && stalls < 200) begin
            stalls++;
            if (mem_read) begin
                fetch_n++;
                if (fetch_n == 1) seen_maddr = mem_addr;
                if (fetch_n == r) begin
                    mem_ready = 1'b1;
                    mem_rdata = line_data(mem_addr);
                end
            end
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
        end
        chk({tag, "_stalls"}, 128'(stalls), exp_miss ? 128'(r + 2) : 128'd0);
        if (exp_miss) chk({tag, "_maddr"}, 128'(seen_maddr), 128'(a[29:2]));
        chk({tag, "_rdata"}, 128'(proc_rdata), 128'({2'b00, a} + 32'd1));
    endtask

    initial begin
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        proc_addr  = 30'd0;
        mem_rdata  = 128'd0;
        mem_ready  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_read", 128'(mem_read), 128'd0);
        chk("rst_stall", 128'(proc_stall), 128'd0);
        chk("rst_maddr", 128'(mem_addr), 128'd0);
        chk("rst_cnt", 128'(miss_cnt), 128'd0);
        chk("rst_mem_write", 128'(mem_write), 128'd0);
        chk("rst_mem_wdata", mem_wdata, 128'd0);
        @(negedge clk);
        proc_reset = 1'b0;
        #1;
        chk("idle_noread_stall", 128'(proc_stall), 128'd0);
        chk("idle_noread_rdata", 128'(proc_rdata), 128'd0);

        // First miss: R=4 gives 6 stall cycles and word 1 of line 0
        access("first", 30'h1, 4, 1'b1);
        chk("first_cnt", 128'(miss_cnt), 128'd1);

        access("seq0", 30'h0, 1, 1'b0);
        access("seq1", 30'h1, 1, 1'b0);
        access("seq2", 30'h2, 1, 1'b0);
        access("seq3", 30'h3, 1, 1'b0);
        chk("seq_cnt", 128'(miss_cnt), 128'd1);

        // Conflict on index 0
        access("conf_a", 30'h20, 2, 1'b1);
        access("conf_b", 30'h0, 1, 1'b1);
        chk("conf_cnt", 128'(miss_cnt), 128'd3);

        // Address switch while the refill of line 1 is in flight
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = 30'h4;
        #1;
        chk("sw_idle_stall", 128'(proc_stall), 128'd1);
        @(negedge clk);
        #1;
        chk("sw_fetch_rd", 128'(mem_read), 128'd1);
        chk("sw_fetch_maddr", 128'(mem_addr), 128'd1);
        proc_addr = 30'h8;
        #1;
        chk("sw_hold_maddr", 128'(mem_addr), 128'd1);
        chk("sw_fetch_rdata", 128'(proc_rdata), 128'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = line_data(28'h1);
        #1;
        chk("sw_fetch2_maddr", 128'(mem_addr), 128'd1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("sw_refilled_rd", 128'(mem_read), 128'd0);
        chk("sw_refilled_stall", 128'(proc_stall), 128'd1);
        access("sw_new", 30'h8, 3, 1'b1);
        access("sw_line1", 30'h4, 1, 1'b0);
        chk("sw_cnt", 128'(miss_cnt), 128'd5);

        // Reset in the middle of a refill
        @(negedge clk);
        proc_addr = 30'h10;
        proc_read = 1'b1;
        @(negedge clk);
        #1;
        chk("rf_fetch_rd", 128'(mem_read), 128'd1);
        #1;
        proc_reset = 1'b1;
        #1;
        chk("rf_rst_rd", 128'(mem_read), 128'd0);
        chk("rf_rst_stall", 128'(proc_stall), 128'd0);
        chk("rf_rst_cnt", 128'(miss_cnt), 128'd0);
        @(negedge clk);
        proc_reset = 1'b0;
        proc_read  = 1'b0;
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = line_data(28'h4);
        #1;
        chk("rf_late_rd", 128'(mem_read), 128'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("rf_after_rd", 128'(mem_read), 128'd0);
        chk("rf_after_stall", 128'(proc_stall), 128'd0);
        access("rf_same", 30'h10, 2, 1'b1);
        access("rf_line0", 30'h1, 1, 1'b1);
        chk("rf_cnt", 128'(miss_cnt), 128'd2);

        // Saturation: preload just below the limit, then three misses
        @(negedge clk);
        force dut.miss_cnt_r = 16'hFFFE;
        #1;
        release dut.miss_cnt_r;
        #1;
        chk("sat_preload", 128'(miss_cnt), 128'hFFFE);
        access("sat_a", 30'h100, 1, 1'b1);
        chk("sat_cnt_a", 128'(miss_cnt), 128'hFFFF);
        access("sat_b", 30'h200, 1, 1'b1);
        access("sat_c", 30'h300, 1, 1'b1);
        chk("sat_cnt_c", 128'(miss_cnt), 128'hFFFF);

        @(negedge clk);
        proc_read = 1'b0;
        #1;
        chk("end_noread_stall", 128'(proc_stall), 128'd0);
        chk("end_noread_rdata", 128'(proc_rdata), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
